// File: rtl/divider_sequential_if.sv
// Handshake bundle for the sequential divider: request (valid_in, n, d) and
// response (busy, valid_out, q, rem, div_zero, overflow).
interface divider_sequential_if #(
    parameter int WIDTH = 32
);
    logic                   valid_in;
    logic [2*WIDTH-1:0]     n;
    logic [WIDTH-1:0]       d;
    logic                   busy;
    logic                   valid_out;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       rem;
    logic                   div_zero;
    logic                   overflow;

    modport master (
        output valid_in, n, d,
        input  busy, valid_out, q, rem, div_zero, overflow
    );

    modport slave (
        input  valid_in, n, d,
        output busy, valid_out, q, rem, div_zero, overflow
    );
endinterface

// File: rtl/divider_sequential.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Optional DIVIDER_EARLY_EXIT_EN: divide-by-zero/overflow skip the iteration loop.
module divider_sequential #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    divider_sequential_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   part_rem;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   n_lo;
    logic [WIDTH-1:0]   d_r;
    logic [CNT_W-1:0]   count;
    logic               dz_r;
    logic               ovf_r;

    logic [WIDTH:0]     t;
    logic               ge;
    logic               accept;
    logic               in_dz;
    logic               in_ovf;

    // Flagged results saturate the quotient; the remainder depends on the flag.
    function automatic logic [WIDTH-1:0] result_q(input logic dz, input logic ovf,
                                                  input logic [WIDTH-1:0] raw);
        return (dz || ovf) ? {WIDTH{1'b1}} : raw;
    endfunction

    function automatic logic [WIDTH-1:0] result_rem(input logic dz, input logic ovf,
                                                    input logic [WIDTH-1:0] raw,
                                                    input logic [WIDTH-1:0] lo);
        if (dz)
            return lo;
        else if (ovf)
            return '0;
        else
            return raw;
    endfunction

    always_comb begin
        t      = {part_rem, shift_q[WIDTH-1]};
        ge     = (t >= {1'b0, d_r});
        accept = bus.valid_in && (state != RUN);
        in_dz  = (bus.d == '0);
        in_ovf = !in_dz && (bus.n[2*WIDTH-1:WIDTH] >= bus.d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            bus.busy      <= 1'b0;
            bus.valid_out <= 1'b0;
            bus.q         <= '0;
            bus.rem       <= '0;
            bus.div_zero  <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                RUN: begin
                    part_rem <= ge ? WIDTH'(t - {1'b0, d_r}) : t[WIDTH-1:0];
                    shift_q  <= {shift_q[WIDTH-2:0], ge};
                    count    <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                DONE: begin
                    bus.valid_out <= 1'b1;
                    bus.q         <= result_q(dz_r, ovf_r, shift_q);
                    bus.rem       <= result_rem(dz_r, ovf_r, part_rem, n_lo);
                    bus.div_zero  <= dz_r;
                    bus.overflow  <= ovf_r;
                    state         <= IDLE;
                end
                default: ;
            endcase

            // A request seen in IDLE or DONE overrides the IDLE return above,
            // which is what lets operations chain back-to-back.
            if (accept) begin
                part_rem <= bus.n[2*WIDTH-1:WIDTH];
                shift_q  <= bus.n[WIDTH-1:0];
                n_lo     <= bus.n[WIDTH-1:0];
                d_r      <= bus.d;
                dz_r     <= in_dz;
                ovf_r    <= in_ovf;
                count    <= CNT_W'(WIDTH);
`ifdef DIVIDER_EARLY_EXIT_EN
                if (in_dz || in_ovf) begin
                    state    <= DONE;
                    bus.busy <= 1'b0;
                end else begin
                    state    <= RUN;
                    bus.busy <= 1'b1;
                end
`else
                state    <= RUN;
                bus.busy <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_divider_sequential.sv
// Scoreboard bench for divider_sequential: a driver queues expected results,
// a monitor pops and compares them whenever valid_out pulses.
module tb_divider_sequential;
    localparam int W   = 32;
    localparam int LAT = W + 1;
`ifdef DIVIDER_EARLY_EXIT_EN
    localparam int LAT_FLAG = 1;
`else
    localparam int LAT_FLAG = W + 1;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] rem;
        logic         dz;
        logic         ovf;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    logic [W-1:0] last_q = '0;

    divider_sequential_if #(.WIDTH(W)) bus ();

    divider_sequential #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid_out pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && bus.valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_out: got q=%h rem=%h expected no result", bus.q, bus.rem);
            end else begin
                e = sb.pop_front();
                check("q",        64'(bus.q),        64'(e.q));
                check("rem",      64'(bus.rem),      64'(e.rem));
                check("div_zero", 64'(bus.div_zero), 64'(e.dz));
                check("overflow", 64'(bus.overflow), 64'(e.ovf));
                check("latency",  64'(cyc - e.acc),  64'(e.lat));
                last_q = e.q;
            end
        end
    end

    // Drive a request (valid_in held until accepted) and queue its expected result.
    task automatic issue(input logic [2*W-1:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] q, input logic [W-1:0] rem,
                         input logic dz, input logic ovf, input int lat);
        exp_t x;
        int   waited;
        @(negedge clk);
        bus.n        = n;
        bus.d        = d;
        bus.valid_in = 1'b1;
        waited = 0;
        while (bus.busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: busy=%b expected 0", bus.busy);
        end
        @(posedge clk);
        #1;
        x.q = q; x.rem = rem; x.dz = dz; x.ovf = ovf; x.lat = lat; x.acc = cyc;
        sb.push_back(x);
        bus.valid_in = 1'b0;
        bus.n        = '0;
        bus.d        = '0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] nn;

        bus.valid_in = 1'b0;
        bus.n        = '0;
        bus.d        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_q",         64'(bus.q),         64'd0);
        check("rst_rem",       64'(bus.rem),       64'd0);
        check("rst_flags",     64'({bus.div_zero, bus.overflow}), 64'd0);
        reset = 1'b0;

        // Basic and boundary divisions
        issue(64'h0000_0001_0000_0000, 32'd2, 32'h8000_0000, 32'd0, 1'b0, 1'b0, LAT);
        issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, LAT);
        issue(64'h0000_0000_0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, LAT_FLAG);
        issue(64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, LAT_FLAG);
        issue(64'hABCD_0000_5555_AAAA, 32'd0, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b1, 1'b0, LAT_FLAG);
        issue(64'd0, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, LAT);
        issue(64'h0000_0000_DEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, LAT);
        issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, LAT);
        drain();
        repeat (3) @(negedge clk);
        check("q_hold", 64'(bus.q), 64'(last_q));

        // Multiplier inverse sweep
        a = 32'h2345_6789;
        b = 32'h3456_7891;
        for (int i = 0; i < 100; i++) begin
            nn = {32'd0, a} * {32'd0, b} + 64'd5;
            issue(nn, b, a, 32'd5, 1'b0, 1'b0, LAT);
            a = a + 32'd1;
            b = b + 32'd1;
        end
        drain();

        // Request mid-RUN is ignored; a request held into DONE chains back-to-back
        issue(64'h0000_0003_0000_0010, 32'd4, 32'hC000_0004, 32'd0, 1'b0, 1'b0, LAT);
        repeat (10) @(negedge clk);
        bus.n        = 64'd999;
        bus.d        = 32'd3;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        issue(64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, LAT);
        drain();

        // Reset five cycles into RUN aborts the operation
        @(negedge clk);
        bus.n        = 64'h0000_0001_0000_0000;
        bus.d        = 32'd3;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy",      64'(bus.busy),      64'd0);
        check("abort_valid_out", 64'(bus.valid_out), 64'd0);
        check("abort_q",         64'(bus.q),         64'd0);
        check("abort_rem",       64'(bus.rem),       64'd0);
        check("abort_flags",     64'({bus.div_zero, bus.overflow}), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_result_q", 64'(bus.q), 64'd0);
        issue(64'h0000_0001_0000_0000, 32'd3, 32'h5555_5555, 32'd1, 1'b0, 1'b0, LAT);
        drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
